// File: rtl/serial_sub_ctrl_pkg.sv
// Shared definitions for the bit-serial subtraction controller: state encoding and default width.
package serial_sub_ctrl_pkg;

    localparam int DEF_WIDTH = 8;

    // Encoding 2'd3 is unused; the controller treats it as IDLE.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_sub_ctrl_full_sub.sv
// One-bit full subtractor cell: d = a - B - bin, with borrow out b.
module full_sub (
    input  logic a,
    input  logic B,
    input  logic bin,
    output logic d,
    output logic b
);

    assign d = a ^ B ^ bin;
    assign b = (~a & B) | (~(a ^ B) & bin);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtraction controller: diff = a - b - bin, one bit per clock, LSB first,
// through a single shared full_sub cell, with a start/busy/done handshake.
module serial_sub_ctrl
    import serial_sub_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             bin_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_diff;
    logic             r_brw;
    logic             r_bout;
    logic             r_ovf;
    logic             w_d;
    logic             w_b;

    full_sub u_cell (
        .a   (r_a_sh[0]),
        .B   (r_b_sh[0]),
        .bin (r_brw),
        .d   (w_d),
        .b   (w_b)
    );

    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE:  w_next = start ? S_RUN : S_IDLE;
            S_RUN:   w_next = (r_cnt == LAST) ? S_DONE : S_RUN;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_diff  <= '0;
            r_brw   <= 1'b0;
            r_bout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a_sh <= a_in;
                        r_b_sh <= b_in;
                        r_brw  <= bin_in;
                        r_cnt  <= '0;
                        r_diff <= '0;
                    end
                end
                S_RUN: begin
                    r_diff <= {w_d, r_diff[WIDTH-1:1]};
                    r_brw  <= w_b;
                    r_a_sh <= r_a_sh >> 1;
                    r_b_sh <= r_b_sh >> 1;
                    r_cnt  <= r_cnt + 1'b1;
                    // Signed overflow: borrow into the MSB differs from borrow out of it.
                    if (r_cnt == LAST) begin
                        r_bout <= w_b;
                        r_ovf  <= r_brw ^ w_b;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);
    assign diff = r_diff;
    assign bout = r_bout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed self-checking bench for serial_sub_ctrl at WIDTH=8.
module tb_serial_sub_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       bin_in;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       bout;
    logic       ovf;

    int n_chk  = 0;
    int n_pass = 0;
    logic [7:0] last_diff;

    serial_sub_ctrl #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a_in   (a_in),
        .b_in   (b_in),
        .bin_in (bin_in),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .bout   (bout),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Launch one subtraction and follow it to its done pulse. With hold=1 start stays
    // high with fresh operands during RUN, which the controller must ignore.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic bin, input logic hold, input logic [7:0] ed,
                          input logic eb, input logic eo);
        int cyc;
        int busy_cnt;
        logic both;
        @(negedge clk);
        check({tag, "_held"}, diff, last_diff);
        start  = 1'b1;
        a_in   = a;
        b_in   = b;
        bin_in = bin;
        cyc = 0;
        busy_cnt = 0;
        both = 1'b0;
        for (int i = 1; i <= 20 && cyc == 0; i++) begin
            @(negedge clk);
            start  = hold;
            a_in   = 8'($urandom);
            b_in   = 8'($urandom);
            bin_in = 1'($urandom);
            if (i == 1) check({tag, "_clr"}, diff, 8'h00);
            if (busy) busy_cnt++;
            if (busy && done) both = 1'b1;
            if (done) begin
                cyc = i;
                start = 1'b0;
            end
        end
        check({tag, "_lat"}, cyc, 9);
        check({tag, "_busy"}, busy_cnt, 8);
        check({tag, "_excl"}, both, 1'b0);
        check({tag, "_diff"}, diff, ed);
        check({tag, "_bout"}, bout, eb);
        check({tag, "_ovf"}, ovf, eo);
        last_diff = ed;
    endtask

    initial begin
        int dn;
        rst = 1'b1;
        start = 1'b0;
        a_in = 8'h00;
        b_in = 8'h00;
        bin_in = 1'b0;
        last_diff = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_diff", diff, 8'h00);
        check("rst_bout", bout, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        rst = 1'b0;

        run_op("basic", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h1E, 1'b0, 1'b0);
        run_op("wrap", 8'h00, 8'h01, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0);
        run_op("binin", 8'h10, 8'h10, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);
        run_op("ovfneg", 8'h80, 8'h01, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b1);
        run_op("ovfpos", 8'h7F, 8'hFF, 1'b0, 1'b0, 8'h80, 1'b1, 1'b1);

        // Abort in the 4th RUN cycle; bout/ovf are 1 from the previous result.
        @(negedge clk);
        start = 1'b1;
        a_in = 8'h33;
        b_in = 8'h11;
        bin_in = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_busy_pre", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_diff", diff, 8'h00);
        check("abort_bout", bout, 1'b0);
        check("abort_ovf", ovf, 1'b0);
        dn = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) dn++;
        end
        check("abort_quiet", dn, 0);
        last_diff = 8'h00;

        run_op("ignore", 8'h05, 8'h03, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0);
        dn = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) dn++;
        end
        check("ignore_noqueue", dn, 0);
        check("ignore_hold", diff, 8'h02);

        run_op("b2b_a", 8'hC8, 8'h64, 1'b0, 1'b0, 8'h64, 1'b0, 1'b1);
        run_op("b2b_b", 8'h01, 8'h02, 1'b1, 1'b0, 8'hFE, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
